cim_slice_sequencer: RTL and testbench
======================================

Name: cim_slice_sequencer

Overview:
- Downstream consumer of the 8-bit-to-2-bit slice decoder in the CIM datapath. It takes the four 36-row slice arrays, each row 3 bits (a 2-bit slice with a zero LSB appended).
- It issues one slice array per transaction to the CIM macro, from slice 0 (bits [1:0]) to slice 3 (bits [7:6]).
- It collects one partial sum per slice, shift-accumulates the partial sums, and outputs the reconstructed full-precision result.
- One job is outstanding at a time; the block holds a single slice in flight.

Parameters:
- N_ROWS, 36, rows per slice array
- SLICE_W, 3, bits per row per slice (2 data bits plus a zero pad bit)
- PSUM_W, 16, width of the unsigned partial sum returned by the macro
- ACC_W, PSUM_W+7, accumulator width (covers the maximum shift of 6 plus carry)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  job request, sampled only in IDLE
- in_ready_o  out  1  high in IDLE
- slice0_i..slice3_i  in  [0:N_ROWS-1][SLICE_W-1:0]  slice arrays from the decoder; latched on an accepted start
- cim_slice_o  out  [0:N_ROWS-1][SLICE_W-1:0]  slice currently presented to the macro
- cim_valid_o  out  1  cim_slice_o is valid
- cim_ready_i  in  1  macro accepts the slice
- psum_i  in  PSUM_W  partial sum from the macro
- psum_valid_i  in  1  psum_i is valid
- result_o  out  ACC_W-1  reconstructed result
- result_valid_o  out  1  one-cycle pulse marking a new result
- busy_o  out  1  high whenever the state is not IDLE

Behaviour:
- Reset: asynchronous and active-high. When asserted, all outputs clear to 0, state goes to IDLE, and the slice index k, the accumulator and the slice registers clear to 0. Reset asserted mid-job abandons the job; no result is produced for it.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready_o=1.
  - On start_i=1: latch slice0..3, set acc=0 and k=0, go to ISSUE.
- ISSUE:
  - cim_valid_o=1 and cim_slice_o=slice_k.
  - Both outputs stay stable until cim_ready_i=1 is seen at a clock edge; then go to WAIT.
- WAIT:
  - cim_valid_o=0.
  - On psum_valid_i=1: acc += psum_i << (2k).
  - If k=3, go to DONE; otherwise k++ and go to ISSUE.
- DONE:
  - result_o = acc >> 1. This drops the pad bit, since every partial sum is twice the true value.
  - result_valid_o=1 for exactly this cycle, then return to IDLE.
  - result_o holds its value until the next DONE.
- Ignored inputs:
  - start_i outside IDLE is ignored; it does not queue.
  - psum_valid_i outside WAIT is ignored, including in the same cycle as the ISSUE handshake.
  - cim_ready_i outside ISSUE is ignored.
- Latency: with cim_ready_i=1 and psum_valid_i arriving one cycle after acceptance, result_valid_o rises 9 cycles after the edge that samples start_i. Each cycle of backpressure or psum delay adds one cycle.
- Arithmetic: unsigned throughout; no saturation, because ACC_W cannot overflow. acc[0] is discarded.
- Back-to-back jobs: the DONE -> IDLE -> start sequence gives at least one idle cycle between jobs.

Decomposition:
- Shared package cim_pkg holds:
  - N_ROWS, SLICE_W and NUM_SLICES=4
  - the cim_slice_t row array typedef
  - the state enum {IDLE, ISSUE, WAIT, DONE}
- One sub-module, cim_shift_acc: the accumulator register with inputs clr, en, shift index k and psum, output acc. The FSM, slice latch and output muxing stay in the top.

Test Plan:
- Ideal job: macro with ready=1 and one-cycle psum returns; psums 2, 4, 6, 8 for k=0..3 -> result_o=313 (acc=626), result_valid_o pulses 9 cycles after start.
- Slice ordering: rows of slice0..3 set to 3'b010, 3'b100, 3'b110, 3'b000 -> cim_slice_o carries exactly those arrays in order k=0,1,2,3, one handshake each.
- Backpressure: cim_ready_i held low 3 cycles during k=1 -> cim_slice_o and cim_valid_o stay stable, result is unchanged, pulse arrives 3 cycles later (cycle 12).
- Maximum value: all four psums = 0xFFFF -> result_o=2785237, no overflow.
- Protocol noise: start_i pulsed during WAIT, and psum_valid_i pulsed during ISSUE and IDLE -> no effect on state or result; busy_o stays high until DONE.
- Reset mid-job: rst asserted in WAIT for k=2 -> all outputs 0 immediately, in_ready_o=1 after release; a following job with psums 2, 4, 6, 8 still yields 313.

Source files
------------

// File: rtl/cim_pkg.sv
// Shared types and sizing for the CIM slice sequencer and its accumulator.
package cim_pkg;

  localparam int unsigned N_ROWS     = 36;
  localparam int unsigned SLICE_W    = 3;
  localparam int unsigned NUM_SLICES = 4;
  localparam int unsigned K_W        = 2;
  localparam int unsigned PSUM_W     = 16;
  localparam int unsigned ACC_W      = PSUM_W + 7;

  typedef logic [0:N_ROWS-1][SLICE_W-1:0] cim_slice_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } cim_state_t;

endpackage

// File: rtl/cim_shift_acc.sv
// Shift-accumulator: adds psum weighted by 4^k into a running unsigned sum.
module cim_shift_acc
  import cim_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [K_W-1:0]    k,
  input  logic [PSUM_W-1:0] psum,
  output logic [ACC_W-1:0]  acc
);

  logic [ACC_W-1:0] addend_c;

  // Each slice carries two bits of weight, so slice k shifts by 2k.
  assign addend_c = ACC_W'(psum) << {k, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + addend_c;
    end
  end

endmodule

// File: rtl/cim_slice_sequencer.sv
// Issues four latched slice arrays to the CIM macro one at a time and
// reconstructs the full-precision result from the returned partial sums.
module cim_slice_sequencer
  import cim_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  output logic                             in_ready_o,
  input  logic [0:N_ROWS-1][SLICE_W-1:0]   slice0_i,
  input  logic [0:N_ROWS-1][SLICE_W-1:0]   slice1_i,
  input  logic [0:N_ROWS-1][SLICE_W-1:0]   slice2_i,
  input  logic [0:N_ROWS-1][SLICE_W-1:0]   slice3_i,
  output logic [0:N_ROWS-1][SLICE_W-1:0]   cim_slice_o,
  output logic                             cim_valid_o,
  input  logic                             cim_ready_i,
  input  logic [PSUM_W-1:0]                psum_i,
  input  logic                             psum_valid_i,
  output logic [ACC_W-2:0]                 result_o,
  output logic                             result_valid_o,
  output logic                             busy_o
);

  cim_state_t       state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  cim_slice_t       slice_q [NUM_SLICES];
  logic [ACC_W-1:0] acc;

  logic             load_c;
  logic             acc_clr_c;
  logic             acc_en_c;

  logic             in_ready_d;
  logic             busy_d;
  logic             cim_valid_d;
  cim_slice_t       cim_slice_d;
  logic [ACC_W-2:0] result_d;
  logic             result_valid_d;

  cim_shift_acc u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc_clr_c),
    .en   (acc_en_c),
    .k    (k_q),
    .psum (psum_i),
    .acc  (acc)
  );

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    load_c         = 1'b0;
    acc_clr_c      = 1'b0;
    acc_en_c       = 1'b0;
    cim_slice_d    = cim_slice_o;
    result_d       = result_o;
    result_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = ISSUE;
          k_d       = '0;
          load_c    = 1'b1;
          acc_clr_c = 1'b1;
        end
      end
      ISSUE: begin
        if (cim_ready_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (psum_valid_i) begin
          acc_en_c = 1'b1;
          if (k_q == K_W'(NUM_SLICES - 1)) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + K_W'(1);
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        // Every partial sum is doubled by the zero pad bit; drop it here.
        result_d       = (ACC_W-1)'(acc >> 1);
        result_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Slice presented on entry to ISSUE; the first one comes straight from the inputs.
    if (state_d == ISSUE && state_q != ISSUE) begin
      cim_slice_d = load_c ? slice0_i : slice_q[k_d];
    end

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    cim_valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      k_q            <= '0;
      in_ready_o     <= 1'b0;
      busy_o         <= 1'b0;
      cim_valid_o    <= 1'b0;
      cim_slice_o    <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      in_ready_o     <= in_ready_d;
      busy_o         <= busy_d;
      cim_valid_o    <= cim_valid_d;
      cim_slice_o    <= cim_slice_d;
      result_o       <= result_d;
      result_valid_o <= result_valid_d;
    end
  end

  // Slice arrays are captured once per job so the decoder may move on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SLICES; i++) begin
        slice_q[i] <= '0;
      end
    end else if (load_c) begin
      slice_q[0] <= slice0_i;
      slice_q[1] <= slice1_i;
      slice_q[2] <= slice2_i;
      slice_q[3] <= slice3_i;
    end
  end

endmodule

// File: tb/tb_cim_slice_sequencer.sv
// Directed self-checking bench for cim_slice_sequencer with a reactive macro model.
module tb_cim_slice_sequencer;
  import cim_pkg::*;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           start_i;
  logic                           in_ready_o;
  logic [0:N_ROWS-1][SLICE_W-1:0] slice0_i, slice1_i, slice2_i, slice3_i;
  logic [0:N_ROWS-1][SLICE_W-1:0] cim_slice_o;
  logic                           cim_valid_o;
  logic                           cim_ready_i;
  logic [PSUM_W-1:0]              psum_i;
  logic                           psum_valid_i;
  logic [ACC_W-2:0]               result_o;
  logic                           result_valid_o;
  logic                           busy_o;

  int n_cmp = 0;
  int n_err = 0;
  cim_slice_t s_exp [4];

  cim_slice_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .in_ready_o     (in_ready_o),
    .slice0_i       (slice0_i),
    .slice1_i       (slice1_i),
    .slice2_i       (slice2_i),
    .slice3_i       (slice3_i),
    .cim_slice_o    (cim_slice_o),
    .cim_valid_o    (cim_valid_o),
    .cim_ready_i    (cim_ready_i),
    .psum_i         (psum_i),
    .psum_valid_i   (psum_valid_i),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_slices(input cim_slice_t a, input cim_slice_t b,
                              input cim_slice_t c, input cim_slice_t d);
    slice0_i = a; slice1_i = b; slice2_i = c; slice3_i = d;
    s_exp[0] = a; s_exp[1] = b; s_exp[2] = c; s_exp[3] = d;
  endtask

  // Macro model: accepts each slice (optionally stalling one), returns psum one cycle later.
  task automatic run_job(input logic [15:0] p0, input logic [15:0] p1,
                         input logic [15:0] p2, input logic [15:0] p3,
                         input int stall_k, input int stall_n, input bit noise,
                         output int lat, output logic [ACC_W-2:0] res);
    logic [15:0] ps [4];
    int idx, stall, cyc, hs;
    bit pend, accepted, seen;
    ps[0] = p0; ps[1] = p1; ps[2] = p2; ps[3] = p3;
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_err++; $display("FAIL job_in_ready got %b want 1", in_ready_o);
    end
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    slice0_i = '1; slice1_i = '1; slice2_i = '1; slice3_i = '1;
    idx = 0; stall = 0; cyc = 0; hs = 0; pend = 0; seen = 0; lat = -1; res = '0;
    while (!seen && cyc < 60) begin
      cim_ready_i = 1'b0; psum_valid_i = 1'b0; psum_i = '0; start_i = 1'b0;
      accepted = 0;
      if (pend) begin
        psum_valid_i = 1'b1;
        psum_i = ps[idx];
        if (noise) start_i = 1'b1;
      end else if (cim_valid_o && idx < 4) begin
        n_cmp++;
        if (cim_slice_o !== s_exp[idx]) begin
          n_err++; $display("FAIL slice_k%0d got %h want %h", idx, cim_slice_o, s_exp[idx]);
        end
        if (idx == stall_k && stall < stall_n) begin
          stall++;
        end else begin
          cim_ready_i = 1'b1;
          accepted = 1;
          hs++;
          if (noise) begin psum_valid_i = 1'b1; psum_i = 16'hFFFF; end
        end
      end
      tick;
      cyc++;
      if (pend) begin pend = 0; idx++; end
      if (accepted) pend = 1;
      if (result_valid_o) begin
        seen = 1; lat = cyc; res = result_o;
        n_cmp++;
        if (busy_o !== 1'b0) begin
          n_err++; $display("FAIL busy_after_done got %b want 0", busy_o);
        end
      end else begin
        n_cmp++;
        if (busy_o !== 1'b1) begin
          n_err++; $display("FAIL busy_in_job cycle %0d got %b want 1", cyc, busy_o);
        end
      end
    end
    cim_ready_i = 1'b0; psum_valid_i = 1'b0; start_i = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL job_timeout got no result_valid want pulse");
    end
    n_cmp++;
    if (hs != 4) begin
      n_err++; $display("FAIL handshakes got %0d want 4", hs);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready_o, busy_o, cim_valid_o, result_valid_o} !== 4'b0 ||
        cim_slice_o !== '0 || result_o !== '0) begin
      n_err++; $display("FAIL reset_outputs got rdy=%b busy=%b v=%b rv=%b res=%0d want all 0",
                        in_ready_o, busy_o, cim_valid_o, result_valid_o, result_o);
    end
    tick; tick;
    rst = 1'b0;
    tick;
    n_cmp++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL reset_release got rdy=%b busy=%b want 1/0", in_ready_o, busy_o);
    end
  endtask

  task automatic test_ideal;
    int lat; logic [ACC_W-2:0] res;
    drive_slices({36{3'b110}}, {36{3'b010}}, {36{3'b100}}, {18{3'b010, 3'b100}});
    run_job(16'd2, 16'd4, 16'd6, 16'd8, -1, 0, 1'b0, lat, res);
    n_cmp++;
    if (res !== 22'd313) begin n_err++; $display("FAIL ideal_result got %0d want 313", res); end
    n_cmp++;
    if (lat != 9) begin n_err++; $display("FAIL ideal_latency got %0d want 9", lat); end
  endtask

  task automatic test_slice_order;
    int lat; logic [ACC_W-2:0] res;
    drive_slices({36{3'b010}}, {36{3'b100}}, {36{3'b110}}, {36{3'b000}});
    run_job(16'd10, 16'd20, 16'd30, 16'd40, -1, 0, 1'b0, lat, res);
    // 10 + 80 + 480 + 2560 = 3130 -> 1565
    n_cmp++;
    if (res !== 22'd1565) begin n_err++; $display("FAIL order_result got %0d want 1565", res); end
  endtask

  task automatic test_backpressure;
    int lat; logic [ACC_W-2:0] res;
    drive_slices({36{3'b010}}, {36{3'b100}}, {36{3'b110}}, {36{3'b000}});
    run_job(16'd2, 16'd4, 16'd6, 16'd8, 1, 3, 1'b0, lat, res);
    n_cmp++;
    if (res !== 22'd313) begin n_err++; $display("FAIL bp_result got %0d want 313", res); end
    n_cmp++;
    if (lat != 12) begin n_err++; $display("FAIL bp_latency got %0d want 12", lat); end
  endtask

  task automatic test_max_value;
    int lat; logic [ACC_W-2:0] res;
    drive_slices({36{3'b110}}, {36{3'b110}}, {36{3'b110}}, {36{3'b110}});
    run_job(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, -1, 0, 1'b0, lat, res);
    n_cmp++;
    if (res !== 22'd2785237) begin n_err++; $display("FAIL max_result got %0d want 2785237", res); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [ACC_W-2:0] res;
    drive_slices({36{3'b010}}, {36{3'b100}}, {36{3'b110}}, {36{3'b000}});
    run_job(16'd2, 16'd4, 16'd6, 16'd8, -1, 0, 1'b0, lat, res);
    n_cmp++;
    if (res !== 22'd313) begin n_err++; $display("FAIL b2b_first got %0d want 313", res); end
    drive_slices({36{3'b100}}, {36{3'b010}}, {36{3'b000}}, {36{3'b110}});
    run_job(16'd10, 16'd0, 16'd0, 16'd0, -1, 0, 1'b0, lat, res);
    n_cmp++;
    if (res !== 22'd5 || lat != 9) begin
      n_err++; $display("FAIL b2b_second got res=%0d lat=%0d want 5/9", res, lat);
    end
    tick;
    n_cmp++;
    if (result_valid_o !== 1'b0 || result_o !== 22'd5) begin
      n_err++; $display("FAIL result_hold got rv=%b res=%0d want 0/5", result_valid_o, result_o);
    end
  endtask

  task automatic test_noise;
    int lat; logic [ACC_W-2:0] res;
    psum_valid_i = 1'b1; psum_i = 16'hFFFF;
    tick; tick;
    psum_valid_i = 1'b0; psum_i = '0;
    drive_slices({36{3'b010}}, {36{3'b100}}, {36{3'b110}}, {36{3'b000}});
    run_job(16'd2, 16'd4, 16'd6, 16'd8, -1, 0, 1'b1, lat, res);
    n_cmp++;
    if (res !== 22'd313 || lat != 9) begin
      n_err++; $display("FAIL noise_result got res=%0d lat=%0d want 313/9", res, lat);
    end
    tick; tick;
    n_cmp++;
    if (busy_o !== 1'b0 || cim_valid_o !== 1'b0) begin
      n_err++; $display("FAIL noise_no_queue got busy=%b v=%b want 0/0", busy_o, cim_valid_o);
    end
  endtask

  task automatic test_reset_mid_job;
    int lat; logic [ACC_W-2:0] res;
    drive_slices({36{3'b010}}, {36{3'b100}}, {36{3'b110}}, {36{3'b000}});
    start_i = 1'b1; tick; start_i = 1'b0;
    cim_ready_i = 1'b1; tick; cim_ready_i = 1'b0;
    psum_valid_i = 1'b1; psum_i = 16'd2; tick; psum_valid_i = 1'b0;
    cim_ready_i = 1'b1; tick; cim_ready_i = 1'b0;
    psum_valid_i = 1'b1; psum_i = 16'd4; tick; psum_valid_i = 1'b0;
    cim_ready_i = 1'b1; tick; cim_ready_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b1 || cim_valid_o !== 1'b0) begin
      n_err++; $display("FAIL midjob_wait got busy=%b v=%b want 1/0", busy_o, cim_valid_o);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready_o, busy_o, cim_valid_o, result_valid_o} !== 4'b0 ||
        cim_slice_o !== '0 || result_o !== '0) begin
      n_err++; $display("FAIL midjob_reset got rdy=%b busy=%b v=%b rv=%b res=%0d want all 0",
                        in_ready_o, busy_o, cim_valid_o, result_valid_o, result_o);
    end
    tick;
    rst = 1'b0;
    tick;
    n_cmp++;
    if (in_ready_o !== 1'b1 || result_valid_o !== 1'b0) begin
      n_err++; $display("FAIL midjob_release got rdy=%b rv=%b want 1/0", in_ready_o, result_valid_o);
    end
    drive_slices({36{3'b010}}, {36{3'b100}}, {36{3'b110}}, {36{3'b000}});
    run_job(16'd2, 16'd4, 16'd6, 16'd8, -1, 0, 1'b0, lat, res);
    n_cmp++;
    if (res !== 22'd313 || lat != 9) begin
      n_err++; $display("FAIL midjob_rerun got res=%0d lat=%0d want 313/9", res, lat);
    end
  endtask

  initial begin
    start_i = 1'b0; cim_ready_i = 1'b0; psum_valid_i = 1'b0; psum_i = '0;
    slice0_i = '0; slice1_i = '0; slice2_i = '0; slice3_i = '0;
    test_reset;
    test_ideal;
    test_slice_order;
    test_backpressure;
    test_max_value;
    test_back_to_back;
    test_noise;
    test_reset_mid_job;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
